// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the program-counter sequencer
package pc_seq_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

  typedef enum logic [2:0] {SEL_HOLD, SEL_SEQ, SEL_JUMP, SEL_BRANCH, SEL_TRAP} pc_sel_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - priority mux choosing the next PC while the core is running
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output pc_sel_t         sel,
  output logic            misaligned
);
  always_comb begin
    sel        = SEL_SEQ;
    next_pc    = pc + 32'd4;
    misaligned = 1'b0;
    if (stall || halt_req) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (jump_valid) begin
      // jump outranks a simultaneous branch; its target alone decides a trap
      if (!is_aligned(jump_target)) begin
        sel        = SEL_TRAP;
        next_pc    = TRAP_VECTOR;
        misaligned = 1'b1;
      end else begin
        sel     = SEL_JUMP;
        next_pc = jump_target;
      end
    end else if (branch_taken) begin
      if (!is_aligned(branch_target)) begin
        sel        = SEL_TRAP;
        next_pc    = TRAP_VECTOR;
        misaligned = 1'b1;
      end else begin
        sel     = SEL_BRANCH;
        next_pc = branch_target;
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, boot/run/halt control, trap capture and fetch counter
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     BOOT_DELAY   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_addr,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            halted,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] instr_count
);
  localparam logic [7:0] BOOT_LAST = 8'(BOOT_DELAY - 1);

  if (RESET_VECTOR[1:0] != 2'b00 || TRAP_VECTOR[1:0] != 2'b00 ||
      BOOT_DELAY < 1 || BOOT_DELAY > 255) begin : g_bad_params
    $error("pc_sequencer: vectors must be word-aligned and BOOT_DELAY within 1..255");
  end

  pc_state_t       state;
  logic [7:0]      boot_cnt;
  logic [XLEN-1:0] next_pc;
  pc_sel_t         sel;
  logic            misaligned;

  assign pc_plus4 = pc_addr + 32'd4;

  pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_sel (
    .pc            (pc_addr),
    .stall         (stall),
    .halt_req      (halt_req),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .sel           (sel),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_addr     <= RESET_VECTOR;
      boot_cnt    <= '0;
      instr_count <= '0;
      trap_valid  <= 1'b0;
      trap_pc     <= '0;
      trap_target <= '0;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      trap_valid <= 1'b0;
      case (state)
        IDLE: begin
          boot_cnt <= boot_cnt + 8'd1;
          if (boot_cnt == BOOT_LAST) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          // a stalled cycle is invisible: no count, no redirect, no halt
          if (!stall) begin
            instr_count <= instr_count + 32'd1;
            if (sel != SEL_HOLD) pc_addr <= next_pc;
            if (halt_req) begin
              state       <= HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
            end
            if (misaligned) begin
              trap_valid  <= 1'b1;
              trap_pc     <= pc_addr;
              trap_target <= jump_valid ? jump_target : branch_target;
            end
          end
        end
        HALT: begin
          if (resume) begin
            pc_addr     <= pc_plus4;
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer with a cycle-level reference model
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          BD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump_valid, halt_req, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_addr, pc_plus4, trap_pc, trap_target, instr_count;
  logic        fetch_valid, halted, trap_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_cnt, m_trap_pc, m_trap_tgt;
  logic        m_trap_v, m_halted;
  int          m_boot;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BOOT_DELAY(BD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump_valid(jump_valid), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume), .pc_addr(pc_addr), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .halted(halted), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_target(trap_target), .instr_count(instr_count)
  );

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump_valid = 0; halt_req = 0; resume = 0;
    branch_target = 0; jump_target = 0;
  endtask

  task automatic model_reset();
    m_pc = RV; m_cnt = 0; m_trap_pc = 0; m_trap_tgt = 0;
    m_trap_v = 0; m_halted = 0; m_boot = BD;
  endtask

  task automatic model_redirect(input logic [31:0] t);
    if (t % 4 != 0) begin
      m_trap_v = 1; m_trap_pc = m_pc; m_trap_tgt = t; m_pc = TV;
    end else begin
      m_pc = t;
    end
  endtask

  // Applies the sequencing rules for one clock edge using the currently driven inputs.
  task automatic model_edge();
    m_trap_v = 0;
    if (m_boot > 0) m_boot--;
    else if (m_halted) begin
      if (resume) begin m_halted = 0; m_pc = m_pc + 4; end
    end else if (!stall) begin
      m_cnt = m_cnt + 1;
      if (halt_req) m_halted = 1;
      else if (jump_valid) model_redirect(jump_target);
      else if (branch_taken) model_redirect(branch_target);
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic jump_to(input logic [31:0] t);
    jump_valid = 1; jump_target = t;
    step();
    jump_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks += 6;
    if (pc_addr !== RV) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_addr, RV); end
    if (fetch_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got fv=%b halted=%b expected 0 0", fetch_valid, halted); end
    if (trap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trap_valid: got %b expected 0", trap_valid); end
    if (trap_pc !== 32'h0 || trap_target !== 32'h0) begin n_fail++; $display("FAIL reset_trap_regs: got %h %h expected 0 0", trap_pc, trap_target); end
    if (instr_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    if (pc_plus4 !== RV + 32'd4) begin n_fail++; $display("FAIL reset_plus4: got %h expected %h", pc_plus4, RV + 32'd4); end
  endtask

  task automatic test_boot();
    for (int i = 1; i <= BD; i++) begin
      step();
      n_checks++;
      if (fetch_valid !== (i == BD)) begin n_fail++; $display("FAIL boot_fetch_valid edge %0d: got %b expected %b", i, fetch_valid, (i == BD)); end
    end
    n_checks++;
    if (pc_addr !== 32'h0) begin n_fail++; $display("FAIL boot_first_pc: got %h expected 0", pc_addr); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (pc_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc step %0d: got %h expected %h", k, pc_addr, 32'(4 * k)); end
    end
    n_checks++;
    if (instr_count !== 32'd3) begin n_fail++; $display("FAIL seq_count: got %0d expected 3", instr_count); end
  endtask

  task automatic test_redirects();
    jump_to(32'h20);
    branch_taken = 1; branch_target = 32'h80;
    step();
    branch_taken = 0;
    n_checks++;
    if (pc_addr !== 32'h80) begin n_fail++; $display("FAIL branch_pc: got %h expected 80", pc_addr); end
    jump_to(32'h200);
    n_checks++;
    if (pc_addr !== 32'h200) begin n_fail++; $display("FAIL jump_pc: got %h expected 200", pc_addr); end
    jump_to(32'h20);
    jump_valid = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h80;
    step();
    clear_inputs();
    n_checks++;
    if (pc_addr !== 32'h200) begin n_fail++; $display("FAIL jump_over_branch: got %h expected 200", pc_addr); end
  endtask

  task automatic test_trap();
    jump_to(32'h40);
    jump_to(32'h102);
    n_checks += 3;
    if (pc_addr !== TV) begin n_fail++; $display("FAIL trap_pc_vector: got %h expected %h", pc_addr, TV); end
    if (trap_valid !== 1'b1) begin n_fail++; $display("FAIL trap_pulse: got %b expected 1", trap_valid); end
    if (trap_pc !== 32'h40 || trap_target !== 32'h102) begin n_fail++; $display("FAIL trap_capture: got %h %h expected 40 102", trap_pc, trap_target); end
    step();
    n_checks += 2;
    if (trap_valid !== 1'b0) begin n_fail++; $display("FAIL trap_pulse_end: got %b expected 0", trap_valid); end
    if (pc_addr !== TV + 32'd4 || trap_pc !== 32'h40) begin n_fail++; $display("FAIL trap_after: got pc %h trap_pc %h expected %h 40", pc_addr, trap_pc, TV + 32'd4); end
  endtask

  task automatic test_stall();
    jump_to(32'h10);
    stall = 1; branch_taken = 1; branch_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (pc_addr !== 32'h10 || instr_count !== m_cnt) begin n_fail++; $display("FAIL stall_hold %0d: got pc %h count %0d expected 10 %0d", i, pc_addr, instr_count, m_cnt); end
    end
    stall = 0;
    step();
    clear_inputs();
    n_checks++;
    if (pc_addr !== 32'h300 || instr_count !== m_cnt) begin n_fail++; $display("FAIL stall_release: got pc %h count %0d expected 300 %0d", pc_addr, instr_count, m_cnt); end
  endtask

  task automatic test_halt();
    jump_to(32'h50);
    halt_req = 1;
    step();
    halt_req = 0;
    n_checks++;
    if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc_addr !== 32'h50) begin n_fail++; $display("FAIL halt_enter: got halted %b fv %b pc %h expected 1 0 50", halted, fetch_valid, pc_addr); end
    for (int i = 0; i < 5; i++) begin
      jump_valid = 1; jump_target = 32'h700;
      step();
      n_checks++;
      if (pc_addr !== 32'h50 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold %0d: got pc %h halted %b expected 50 1", i, pc_addr, halted); end
    end
    clear_inputs();
    resume = 1;
    step();
    resume = 0;
    n_checks++;
    if (pc_addr !== 32'h54 || fetch_valid !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL resume: got pc %h fv %b halted %b expected 54 1 0", pc_addr, fetch_valid, halted); end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    n_checks++;
    if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h expected 0", pc_plus4); end
    step();
    n_checks++;
    if (pc_addr !== 32'h0 || trap_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_pc: got %h trap %b expected 0 0", pc_addr, trap_valid); end
  endtask

  task automatic test_async_reset();
    step(); step();
    #2;
    rst = 1;
    model_reset();
    #1;
    n_checks++;
    if (pc_addr !== RV || instr_count !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc %h count %0d fv %b expected %h 0 0", pc_addr, instr_count, fetch_valid, RV); end
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] t;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      stall        = ($urandom_range(0, 4) == 0);
      halt_req     = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      jump_valid   = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      jump_target = ($urandom_range(0, 3) == 0) ? (t | 32'($urandom_range(1, 3))) : t;
      t = $urandom & 32'hFFFF_FFFC;
      branch_target = ($urandom_range(0, 3) == 0) ? (t | 32'($urandom_range(1, 3))) : t;
      step();
      n_checks += 4;
      if (pc_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_pc cycle %0d: got %h %h expected %h", c, pc_addr, pc_plus4, m_pc); end
      if (fetch_valid !== (m_boot == 0 && !m_halted) || halted !== m_halted) begin n_fail++; $display("FAIL rand_flags cycle %0d: got fv %b halted %b expected %b %b", c, fetch_valid, halted, (m_boot == 0 && !m_halted), m_halted); end
      if (instr_count !== m_cnt) begin n_fail++; $display("FAIL rand_count cycle %0d: got %0d expected %0d", c, instr_count, m_cnt); end
      if (trap_valid !== m_trap_v || trap_pc !== m_trap_pc || trap_target !== m_trap_tgt) begin n_fail++; $display("FAIL rand_trap cycle %0d: got %b %h %h expected %b %h %h", c, trap_valid, trap_pc, trap_target, m_trap_v, m_trap_pc, m_trap_tgt); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_boot();
    test_redirects();
    test_trap();
    test_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
